bp_me_clint_fwd_arbiter: RTL

- Shares one CLINT slice's single-beat BedRock mem_fwd/mem_rev port pair among num_req_p requesters (cores / host bridge).
- Arbitrates mem_fwd round-robin with grant lock across backpressure.
- Tracks requester IDs of outstanding requests in order and steers each mem_rev response back to its originator.
- Sits between the per-tile I/O crossbar outputs and the CLINT slice.

---
 rtl/bp_me_clint_fwd_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bp_me_clint_fwd_arbiter.sv
// Shares one CLINT slice's single-beat mem_fwd/mem_rev pair among num_req_p requesters.
// Round-robin fwd grant with lock across backpressure; in-order ID tracker steers responses back.
module bp_me_clint_fwd_arbiter #(
  parameter int num_req_p      = 4,
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64,
  parameter int els_p          = 4,
  localparam int lg_req_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int cnt_w_lp      = $clog2(els_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p*header_width_p-1:0] req_fwd_header_i,
  input  logic [num_req_p*data_width_p-1:0]   req_fwd_data_i,
  input  logic [num_req_p-1:0]                req_fwd_v_i,
  output logic [num_req_p-1:0]                req_fwd_ready_and_o,
  output logic [header_width_p-1:0]           req_rev_header_o,
  output logic [data_width_p-1:0]             req_rev_data_o,
  output logic [num_req_p-1:0]                req_rev_v_o,
  input  logic [num_req_p-1:0]                req_rev_ready_and_i,
  output logic [header_width_p-1:0]           mem_fwd_header_o,
  output logic [data_width_p-1:0]             mem_fwd_data_o,
  output logic                                mem_fwd_v_o,
  input  logic                                mem_fwd_ready_and_i,
  input  logic [header_width_p-1:0]           mem_rev_header_i,
  input  logic [data_width_p-1:0]             mem_rev_data_i,
  input  logic                                mem_rev_v_i,
  output logic                                mem_rev_ready_and_o,
  output logic [cnt_w_lp-1:0]                 outstanding_o,
  output logic                                error_o
);

  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [lg_req_lp-1:0] rr_ptr_q, lock_id_q;
  logic                 lock_q;
  logic [lg_req_lp-1:0] id_mem_q [els_p];
  logic [lg_els_lp-1:0] wptr_q, rptr_q;
  logic [cnt_w_lp-1:0]  count_q, count_d;
  logic                 error_q;

  logic                 full, empty;
  logic                 grant_v;
  logic [lg_req_lp-1:0] grant_id;
  logic [lg_req_lp:0]   cand_sum;
  logic [lg_req_lp-1:0] cand;
  logic [lg_req_lp-1:0] head;
  logic                 fwd_hs, rev_hs;

  assign full  = (count_q == cnt_w_lp'(els_p));
  assign empty = (count_q == '0);
  assign head  = id_mem_q[rptr_q];

  // Locked grant ignores other valids; fresh grants need tracker space (registered count).
  always_comb begin
    grant_v  = 1'b0;
    grant_id = lock_id_q;
    cand_sum = '0;
    cand     = '0;
    if (lock_q) begin
      grant_v = req_fwd_v_i[lock_id_q];
    end else if (!full) begin
      for (int i = 0; i < num_req_p; i++) begin
        cand_sum = {1'b0, rr_ptr_q} + (lg_req_lp+1)'(i);
        if (cand_sum >= (lg_req_lp+1)'(num_req_p))
          cand_sum = cand_sum - (lg_req_lp+1)'(num_req_p);
        cand = cand_sum[lg_req_lp-1:0];
        if (!grant_v && req_fwd_v_i[cand]) begin
          grant_v  = 1'b1;
          grant_id = cand;
        end
      end
    end
    grant_v = grant_v & ~reset_i;
  end

  always_comb begin
    mem_fwd_header_o    = '0;
    mem_fwd_data_o      = '0;
    req_fwd_ready_and_o = '0;
    req_rev_v_o         = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant_id == lg_req_lp'(i)) begin
        mem_fwd_header_o       = req_fwd_header_i[i*header_width_p +: header_width_p];
        mem_fwd_data_o         = req_fwd_data_i[i*data_width_p +: data_width_p];
        req_fwd_ready_and_o[i] = grant_v & mem_fwd_ready_and_i;
      end
      if (head == lg_req_lp'(i))
        req_rev_v_o[i] = mem_rev_v_i & ~empty & ~reset_i;
    end
  end

  assign mem_fwd_v_o = grant_v;
  assign fwd_hs      = grant_v & mem_fwd_ready_and_i;

  // With an empty tracker, any response is an orphan: accept and drop it.
  assign mem_rev_ready_and_o = ~reset_i & (empty ? mem_rev_v_i : req_rev_ready_and_i[head]);
  assign rev_hs              = mem_rev_v_i & mem_rev_ready_and_o & ~empty;

  assign req_rev_header_o = mem_rev_header_i;
  assign req_rev_data_o   = mem_rev_data_i;

  assign count_d = count_q + cnt_w_lp'(fwd_hs) - cnt_w_lp'(rev_hs);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (grant_v && !mem_fwd_ready_and_i) begin
        lock_q    <= 1'b1;
        lock_id_q <= grant_id;
      end
      if (fwd_hs) begin
        lock_q   <= 1'b0;
        rr_ptr_q <= (grant_id == lg_req_lp'(num_req_p-1)) ? '0 : grant_id + 1'b1;
        wptr_q   <= (wptr_q == lg_els_lp'(els_p-1)) ? '0 : wptr_q + 1'b1;
      end
      if (rev_hs)
        rptr_q <= (rptr_q == lg_els_lp'(els_p-1)) ? '0 : rptr_q + 1'b1;
      if (mem_rev_v_i && empty)
        error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fwd_hs)
      id_mem_q[wptr_q] <= grant_id;
  end

  assign outstanding_o = count_q;
  assign error_o       = error_q;

endmodule
